// File: rtl/crc32_slice4_engine_if.sv
// Stream, lookup-table and result signals of the slicing-by-4 CRC engine.
// The engine is the slave; the packet source and the table instances together form the master side.
interface crc32_slice4_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_sop;
    logic         in_eop;
    logic [1:0]   in_bytes;
    logic [31:0]  tab_addr;
    logic [127:0] tab_rdata;
    logic [31:0]  crc_out;
    logic         crc_valid;
    logic         frame_err;

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, in_bytes, tab_rdata,
        output in_ready, tab_addr, crc_out, crc_valid, frame_err
    );

    modport master (
        output in_valid, in_data, in_sop, in_eop, in_bytes, tab_rdata,
        input  in_ready, tab_addr, crc_out, crc_valid, frame_err
    );
endinterface

// File: rtl/crc32_slice4_engine.sv
// Word-serial slicing-by-4 CRC-32 engine driving four external 256x32 lookup tables.
// Tail bytes (1..3) of a frame are finished byte-serially through lane T0.
module crc32_slice4_engine #(
    parameter logic [31:0] INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    crc32_slice4_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

    state_t      r_state,     w_state_nxt;
    logic [31:0] r_crc,       w_crc_nxt;
    logic [31:0] r_crc_out,   w_crc_out_nxt;
    logic [31:0] r_tail_data, w_tail_data_nxt;
    logic [1:0]  r_tail_cnt,  w_tail_cnt_nxt;
    logic        r_crc_valid, w_crc_valid_nxt;
    logic        r_frame_err, w_frame_err_nxt;

    logic        w_ready;
    logic        w_accept;
    logic [31:0] w_c;
    logic [7:0]  w_tail_idx;
    logic [31:0] w_word_crc;
    logic [31:0] w_tail_crc;

    assign w_ready  = (r_state != TAIL);
    assign w_accept = bus.in_valid & w_ready;

    assign w_c        = (bus.in_sop ? INIT : r_crc) ^ bus.in_data;
    assign w_tail_idx = r_crc[7:0] ^ r_tail_data[7:0];

    // Lowest stream byte has the most zero bytes still to pass, hence goes to T3.
    assign bus.tab_addr = (r_state == TAIL) ? {24'h000000, w_tail_idx}
                                            : {w_c[7:0], w_c[15:8], w_c[23:16], w_c[31:24]};

    assign w_word_crc = bus.tab_rdata[127:96] ^ bus.tab_rdata[95:64]
                      ^ bus.tab_rdata[63:32]  ^ bus.tab_rdata[31:0];
    assign w_tail_crc = {8'h00, r_crc[31:8]} ^ bus.tab_rdata[31:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_crc_nxt       = r_crc;
        w_crc_out_nxt   = r_crc_out;
        w_tail_data_nxt = r_tail_data;
        w_tail_cnt_nxt  = r_tail_cnt;
        w_crc_valid_nxt = 1'b0;
        w_frame_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!bus.in_sop) begin
                        w_frame_err_nxt = 1'b1;
                    end else if (bus.in_eop && bus.in_bytes != 2'd0) begin
                        w_crc_nxt       = INIT;
                        w_tail_data_nxt = bus.in_data;
                        w_tail_cnt_nxt  = bus.in_bytes;
                        w_state_nxt     = TAIL;
                    end else begin
                        w_crc_nxt = w_word_crc;
                        if (bus.in_eop) begin
                            w_crc_out_nxt   = w_word_crc ^ XOROUT;
                            w_crc_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt = RUN;
                        end
                    end
                end
            end
            RUN: begin
                if (w_accept) begin
                    // A sop here aborts the open frame and restarts on this word.
                    w_frame_err_nxt = bus.in_sop;
                    if (bus.in_eop && bus.in_bytes != 2'd0) begin
                        if (bus.in_sop) begin
                            w_crc_nxt = INIT;
                        end
                        w_tail_data_nxt = bus.in_data;
                        w_tail_cnt_nxt  = bus.in_bytes;
                        w_state_nxt     = TAIL;
                    end else begin
                        w_crc_nxt = w_word_crc;
                        if (bus.in_eop) begin
                            w_crc_out_nxt   = w_word_crc ^ XOROUT;
                            w_crc_valid_nxt = 1'b1;
                            w_state_nxt     = IDLE;
                        end
                    end
                end
            end
            TAIL: begin
                w_crc_nxt       = w_tail_crc;
                w_tail_data_nxt = {8'h00, r_tail_data[31:8]};
                w_tail_cnt_nxt  = r_tail_cnt - 2'd1;
                if (r_tail_cnt == 2'd1) begin
                    w_crc_out_nxt   = w_tail_crc ^ XOROUT;
                    w_crc_valid_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_crc       <= '0;
            r_crc_out   <= '0;
            r_tail_data <= '0;
            r_tail_cnt  <= '0;
            r_crc_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_crc       <= w_crc_nxt;
            r_crc_out   <= w_crc_out_nxt;
            r_tail_data <= w_tail_data_nxt;
            r_tail_cnt  <= w_tail_cnt_nxt;
            r_crc_valid <= w_crc_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.crc_out   = r_crc_out;
    assign bus.crc_valid = r_crc_valid;
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_crc32_slice4_engine.sv
// Directed and random frame bench for crc32_slice4_engine with a bit-serial CRC-32 reference
// and a scoreboard of expected CRCs popped on every crc_valid pulse.
module tb_crc32_slice4_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crc32_slice4_engine_if bus();

    crc32_slice4_engine #(
        .INIT   (32'hFFFFFFFF),
        .XOROUT (32'hFFFFFFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] t0 [256];
    logic [31:0] t1 [256];
    logic [31:0] t2 [256];
    logic [31:0] t3 [256];

    assign bus.tab_rdata = {t3[bus.tab_addr[31:24]], t2[bus.tab_addr[23:16]],
                            t1[bus.tab_addr[15:8]],  t0[bus.tab_addr[7:0]]};

    int          n_checks     = 0;
    int          n_fail       = 0;
    int          n_valid_seen = 0;
    int          n_err_seen   = 0;
    int          n_pushed     = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  fr_q  [$];

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h000000, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] ref_crc();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (fr_q[i]) c = crc_byte(c, fr_q[i]);
        return c ^ 32'hFFFFFFFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) n_err_seen++;
        if (bus.crc_valid === 1'b1) begin
            n_valid_seen++;
            if (exp_q.size() == 0) check("unexpected_crc_valid", {31'h0, bus.crc_valid}, 32'h0);
            else                   check("scoreboard_crc", bus.crc_out, exp_q.pop_front());
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic sop, input logic eop,
                             input logic [1:0] nb);
        int unsigned waited;
        waited       = 0;
        bus.in_data  = d;
        bus.in_sop   = sop;
        bus.in_eop   = eop;
        bus.in_bytes = nb;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (bus.in_ready !== 1'b1) check("accept_timeout", {31'h0, bus.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_bytes = 2'($urandom_range(0, 3));
    endtask

    task automatic send_frame(input bit expect_crc, input int unsigned max_gap);
        int unsigned len, nw, last_n;
        logic [31:0] d;
        len    = fr_q.size();
        nw     = (len + 3) / 4;
        last_n = len - 4 * (nw - 1);
        for (int unsigned k = 0; k < nw; k++) begin
            for (int unsigned b = 0; b < 4; b++) begin
                d[8*b +: 8] = (4*k + b < len) ? fr_q[4*k + b] : 8'($urandom);
            end
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            if (k == nw - 1 && expect_crc) begin
                exp_q.push_back(ref_crc());
                n_pushed++;
            end
            send_word(d, k == 0, k == nw - 1, 2'(last_n % 4));
        end
    endtask

    task automatic rand_frame(input int unsigned len);
        fr_q.delete();
        for (int unsigned i = 0; i < len; i++) fr_q.push_back(8'($urandom));
    endtask

    task automatic drain();
        int unsigned w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("drain_queue_empty", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_bytes = '0;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            t0[i] = c;
        end
        for (int i = 0; i < 256; i++) t1[i] = (t0[i] >> 8) ^ t0[8'(t0[i])];
        for (int i = 0; i < 256; i++) t2[i] = (t1[i] >> 8) ^ t0[8'(t1[i])];
        for (int i = 0; i < 256; i++) t3[i] = (t2[i] >> 8) ^ t0[8'(t2[i])];

        #12;
        check("reset_crc_out",   bus.crc_out, 32'h0);
        check("reset_crc_valid", {31'h0, bus.crc_valid}, 32'h0);
        check("reset_frame_err", {31'h0, bus.frame_err}, 32'h0);
        check("reset_in_ready",  {31'h0, bus.in_ready},  32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // "123456789": one TAIL cycle, crc_valid one cycle after the eop edge
        exp_q.push_back(32'hCBF43926);
        n_pushed++;
        send_word(32'h34333231, 1'b1, 1'b0, 2'd0);
        send_word(32'h38373635, 1'b0, 1'b0, 2'd0);
        send_word(32'h00000039, 1'b0, 1'b1, 2'd1);
        @(negedge clk);
        check("check9_tail_in_ready", {31'h0, bus.in_ready},  32'h0);
        check("check9_tail_valid",    {31'h0, bus.crc_valid}, 32'h0);
        @(negedge clk);
        check("check9_valid",    {31'h0, bus.crc_valid}, 32'h1);
        check("check9_in_ready", {31'h0, bus.in_ready},  32'h1);
        check("check9_crc",      bus.crc_out, 32'hCBF43926);
        @(posedge clk);
        #1;

        exp_q.push_back(32'hD202EF8D);
        n_pushed++;
        send_word(32'h00000000, 1'b1, 1'b1, 2'd1);
        @(negedge clk);
        check("one_byte_tail_valid", {31'h0, bus.crc_valid}, 32'h0);
        @(negedge clk);
        check("one_byte_valid", {31'h0, bus.crc_valid}, 32'h1);
        check("one_byte_crc",   bus.crc_out, 32'hD202EF8D);
        @(posedge clk);
        #1;

        exp_q.push_back(32'h2144DF1C);
        n_pushed++;
        send_word(32'h00000000, 1'b1, 1'b1, 2'd0);
        @(negedge clk);
        check("four_zero_valid", {31'h0, bus.crc_valid}, 32'h1);
        check("four_zero_crc",   bus.crc_out, 32'h2144DF1C);
        @(posedge clk);
        #1;

        send_word(32'hDEADBEEF, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        check("nosop_frame_err", {31'h0, bus.frame_err}, 32'h1);
        check("nosop_no_valid",  {31'h0, bus.crc_valid}, 32'h0);
        check("nosop_crc_held",  bus.crc_out, 32'h2144DF1C);
        @(posedge clk);
        #1;

        e0 = n_err_seen;
        send_word(32'h11111111, 1'b1, 1'b0, 2'd0);
        rand_frame(9);
        send_frame(1'b1, 0);
        drain();
        check("midsop_err_count", 32'(n_err_seen - e0), 32'h1);

        send_word(32'h22222222, 1'b1, 1'b0, 2'd0);
        fr_q.delete();
        for (int i = 0; i < 4; i++) fr_q.push_back(8'(8'hA0 + i));
        exp_q.push_back(ref_crc());
        n_pushed++;
        send_word(32'hA3A2A1A0, 1'b1, 1'b1, 2'd0);
        @(negedge clk);
        check("sop_eop_in_run_err",   {31'h0, bus.frame_err}, 32'h1);
        check("sop_eop_in_run_valid", {31'h0, bus.crc_valid}, 32'h1);
        @(posedge clk);
        #1;

        for (int f = 0; f < 40; f++) begin
            rand_frame($urandom_range(1, 64));
            send_frame(1'b1, ($urandom_range(0, 1) == 0) ? 0 : 3);
        end
        drain();

        send_word(32'h00CCBBAA, 1'b1, 1'b1, 2'd3);
        #1;
        rst = 1'b1;
        #1;
        check("rst_tail_crc_out",   bus.crc_out, 32'h0);
        check("rst_tail_crc_valid", {31'h0, bus.crc_valid}, 32'h0);
        check("rst_tail_frame_err", {31'h0, bus.frame_err}, 32'h0);
        check("rst_tail_in_ready",  {31'h0, bus.in_ready},  32'h1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rand_frame(7);
        send_frame(1'b1, 1);
        drain();

        repeat (5) @(posedge clk);
        #1;
        check("valid_pulse_count", 32'(n_valid_seen), 32'(n_pushed));
        check("frame_err_count",   32'(n_err_seen),   32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
